// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial data, config load and match outputs.
// The master side (stream source / config owner) drives data and config,
// the slave side (the detector) returns the match pulse and the match count.
interface seq_detector_param_if #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output in, in_valid, cfg_load, cfg_pat, cfg_len, cfg_ovl,
        input  out, match_cnt
    );

    modport slave (
        input  in, in_valid, cfg_load, cfg_pat, cfg_len, cfg_ovl,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial sequence detector (Mealy).
// Pattern (1..PAT_W bits, MSB first), length and overlap mode load at runtime;
// out fires combinationally in the cycle the final matching bit is presented.
// Optional feature macro: SEQDET_MATCH_CNT_EN -- when defined, a saturating
// match counter drives match_cnt; when undefined, match_cnt is tied to 0.
module seq_detector_param #(
    parameter int               PAT_W       = 16,
    parameter int               LEN_W       = 5,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] PAT_DEF     = PAT_W'(16'hA),
    parameter int               PAT_LEN_DEF = 4,
    parameter bit               OVL_DEF     = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);

    // History keeps only PAT_W-1 bits: the comparison window is {hist, in}
    // and never reaches above bit PAT_W-1, so an older bit is never looked at.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic             ovl_q,  ovl_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] bit_ok;
    logic             cfg_ok;
    logic             fill_ok;
    logic             pat_eq;
    logic             match;

    // Newest PAT_W bits of the stream including the bit on the wire now.
    assign window = {hist_q, bus.in};

    // A zero or over-long length disables detection but not history tracking.
    assign cfg_ok = (len_q != '0) && ({1'b0, len_q} <= (LEN_W+1)'(PAT_W));

    // fill >= len-1 written as fill+1 >= len so len=0 cannot underflow.
    assign fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});

    // Per-bit compare; bits at or above len are don't-care.
    for (genvar i = 0; i < PAT_W; i++) begin : g_cmp
        assign bit_ok[i] = ((LEN_W+1)'(i) >= {1'b0, len_q}) || (window[i] == pat_q[i]);
    end
    assign pat_eq = &bit_ok;

    // A cfg_load cycle drops its input bit, and reset forces the pulse low.
    assign match = !rst && !bus.cfg_load && bus.in_valid && cfg_ok && fill_ok && pat_eq;

    assign bus.out = match;

    // Next-state for config and history; config load outranks the data bit.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pat;
            len_d  = bus.cfg_len;
            ovl_d  = bus.cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            if (match && !ovl_q) begin
                // Non-overlapping: the next match must be built from fresh bits.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                fill_d = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
            end
        end
    end

    // State registers; reset returns the build-time default pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_DEF;
            len_q  <= LEN_W'(PAT_LEN_DEF);
            ovl_q  <= OVL_DEF;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match count, cleared by a config load.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cfg_load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param. Two instances share the
// stimulus: CNT_W=8 and CNT_W=2 (the latter exercises counter saturation).
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        in;
        logic        vld;
        logic        load;
        logic [15:0] pat;
        logic [4:0]  len;
        logic        ovl;
        logic        exp_out;
        int          exp_cnt;   // match_cnt seen during this cycle (before its edge)
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_in, d_vld, d_load, d_ovl;
    logic [15:0] d_pat;
    logic [4:0]  d_len;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    seq_detector_param_if #(.PAT_W(16), .LEN_W(5), .CNT_W(8)) if1 ();
    seq_detector_param_if #(.PAT_W(16), .LEN_W(5), .CNT_W(2)) if2 ();

    assign if1.in = d_in;   assign if1.in_valid = d_vld; assign if1.cfg_load = d_load;
    assign if1.cfg_pat = d_pat; assign if1.cfg_len = d_len; assign if1.cfg_ovl = d_ovl;
    assign if2.in = d_in;   assign if2.in_valid = d_vld; assign if2.cfg_load = d_load;
    assign if2.cfg_pat = d_pat; assign if2.cfg_len = d_len; assign if2.cfg_ovl = d_ovl;

    seq_detector_param #(.PAT_W(16), .LEN_W(5), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    seq_detector_param #(.PAT_W(16), .LEN_W(5), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic i, logic v, logic l, logic [15:0] p,
                                logic [4:0] n, logic o, logic eo, int ec);
        vec_t x;
        x.rst = r; x.in = i; x.vld = v; x.load = l; x.pat = p; x.len = n; x.ovl = o;
        x.exp_out = eo; x.exp_cnt = ec;
        return x;
    endfunction

    // Shorthands: valid data bit, idle (in_valid=0) cycle, config load cycle.
    function automatic void b(logic i, logic eo, int ec);
        tbl.push_back(mk(1'b0, i, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, eo, ec));
    endfunction
    function automatic void gap(logic i, int ec);
        tbl.push_back(mk(1'b0, i, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, ec));
    endfunction
    function automatic void ld(logic [15:0] p, logic [4:0] n, logic o, logic i, int ec);
        tbl.push_back(mk(1'b0, i, 1'b1, 1'b1, p, n, o, 1'b0, ec));
    endfunction

    function automatic int sat3(int c);
        return (c > 3) ? 3 : c;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle just after the edge; sample outputs on the falling edge.
    task automatic step(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        rst = v.rst; d_in = v.in; d_vld = v.vld; d_load = v.load;
        d_pat = v.pat; d_len = v.len; d_ovl = v.ovl;
        @(negedge clk);
        chk("out",  idx, int'(if1.out), int'(v.exp_out));
        chk("out2", idx, int'(if2.out), int'(v.exp_out));
        chk("cnt",  idx, int'(if1.match_cnt), CNT_EN ? v.exp_cnt : 0);
        chk("cnt2", idx, int'(if2.match_cnt), CNT_EN ? sat3(v.exp_cnt) : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lp;
        int          k;
        rst = 1'b1; d_in = 1'b0; d_vld = 1'b0; d_load = 1'b0;
        d_pat = '0; d_len = '0; d_ovl = 1'b0;

        // Hand-written: reset state, then reset mid-stream discards 101 progress.
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), 1000);
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), 1001);
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0), 1002);
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), 1003);
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0), 1004);
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), 1005);  // would complete 1010 without reset
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), 1006);
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0), 1007);
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), 1008);

        // Default 1010, non-overlapping: hits on bits 4 and 8.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        b(1,0,0); b(0,0,0); b(1,0,0); b(0,1,0);
        b(1,0,1); b(0,0,1); b(1,0,1); b(0,1,1);
        gap(0, 2);

        // Overlapping 1010: hits on bits 4, 6, 8.
        ld(16'h000A, 5'd4, 1'b1, 1'b1, 2);
        b(1,0,0); b(0,0,0); b(1,0,0); b(0,1,0);
        b(1,0,1); b(0,1,1); b(1,0,2); b(0,1,2);

        // Full-width pattern B2E1 twice, non-overlapping, with idle gaps.
        ld(16'hB2E1, 5'd16, 1'b0, 1'b0, 3);
        lp = 16'hB2E1;
        for (int i = 0; i < 32; i++) begin
            k = (i >= 16) ? 1 : 0;
            if (i % 5 == 2) gap(~lp[15 - (i % 16)], k);
            b(lp[15 - (i % 16)], (i == 15 || i == 31), k);
        end
        gap(0, 2);

        // Load coincident with a would-be final bit: bit dropped, count cleared.
        ld(16'h000A, 5'd4, 1'b0, 1'b1, 2);
        b(1,0,0); b(0,0,0); b(1,0,0); b(0,1,0);
        b(1,0,1); b(0,0,1); b(1,0,1);
        ld(16'h000A, 5'd4, 1'b0, 1'b0, 1);
        gap(0, 0);
        b(1,0,0); b(0,0,0); b(1,0,0); b(0,1,0);

        // Length 0 and length > PAT_W never match.
        ld(16'h0000, 5'd0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 6; i++) b(0, 0, 0);
        ld(16'h0000, 5'd17, 1'b0, 1'b0, 0);
        for (int i = 0; i < 18; i++) b(0, 0, 0);

        // Length 1, both modes; also drives the CNT_W=2 instance into saturation.
        ld(16'h0001, 5'd1, 1'b0, 1'b1, 0);
        b(1,1,0); b(0,0,1); b(1,1,1); b(1,1,2); b(1,1,3); b(1,1,4); b(1,1,5);
        gap(1, 6);
        ld(16'h0000, 5'd1, 1'b1, 1'b0, 6);
        b(0,1,0); b(1,0,1); b(0,1,1);
        gap(0, 2);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
